conv_feeder: RTL

- Frame sequencer on the producer side of the 3x3 convolver's column interface.
- On start it loads the 3x3 kernel as three column pulses with selecK_I=0.
- It then fetches each image column triple (rows r, r+1, r+2) from pixel memory and pushes it with selecK_I=1.
- It captures the convolver's latched output after each push and writes valid windows to a result memory.

---
 rtl/conv_feeder_if.sv | 62 ++++++
 rtl/conv_feeder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_feeder_if.sv
// conv_feeder_if
//   Bundles everything conv_feeder exchanges with the rest of the system,
//   except the clock and reset.
//
//   Signals:
//     Frame control:  i_start, i_kernel, o_busy, o_done
//     Pixel memory:   o_mem_addr, i_mem_data (1-cycle read latency)
//     Convolver:      o_dato0..2, o_selecK_I, o_valid, i_conv_data
//     Result memory:  o_res_addr, o_res_data, o_res_we
//
//   Modports:
//     master  the feeder itself
//     slave   the surrounding system
//
//   Build option:
//     CONV_FEEDER_PERF_EN  adds the o_cycles busy-cycle counter.
interface conv_feeder_if #(
    parameter int BIT_LEN   = 8,
    parameter int CONV_LPOS = 13,
    parameter int ADDR_LEN  = 16
);
    logic                   i_start;
    logic [9*BIT_LEN-1:0]   i_kernel;
    logic [BIT_LEN-1:0]     i_mem_data;
    logic [CONV_LPOS-1:0]   i_conv_data;
    logic [ADDR_LEN-1:0]    o_mem_addr;
    logic [BIT_LEN-1:0]     o_dato0;
    logic [BIT_LEN-1:0]     o_dato1;
    logic [BIT_LEN-1:0]     o_dato2;
    logic                   o_selecK_I;
    logic                   o_valid;
    logic [ADDR_LEN-1:0]    o_res_addr;
    logic [CONV_LPOS-1:0]   o_res_data;
    logic                   o_res_we;
    logic                   o_busy;
    logic                   o_done;
`ifdef CONV_FEEDER_PERF_EN
    logic [31:0]            o_cycles;

    modport master (
        input  i_start, i_kernel, i_mem_data, i_conv_data,
        output o_mem_addr, o_dato0, o_dato1, o_dato2, o_selecK_I, o_valid,
               o_res_addr, o_res_data, o_res_we, o_busy, o_done, o_cycles
    );
    modport slave (
        output i_start, i_kernel, i_mem_data, i_conv_data,
        input  o_mem_addr, o_dato0, o_dato1, o_dato2, o_selecK_I, o_valid,
               o_res_addr, o_res_data, o_res_we, o_busy, o_done, o_cycles
    );
`else
    modport master (
        input  i_start, i_kernel, i_mem_data, i_conv_data,
        output o_mem_addr, o_dato0, o_dato1, o_dato2, o_selecK_I, o_valid,
               o_res_addr, o_res_data, o_res_we, o_busy, o_done
    );
    modport slave (
        output i_start, i_kernel, i_mem_data, i_conv_data,
        input  o_mem_addr, o_dato0, o_dato1, o_dato2, o_selecK_I, o_valid,
               o_res_addr, o_res_data, o_res_we, o_busy, o_done
    );
`endif
endinterface

// File: rtl/conv_feeder.sv
// conv_feeder
//   Frame sequencer feeding a 3x3 convolver one column at a time.
//   - On start, loads the kernel as three column pushes (selecK_I = 0).
//   - Then streams every image column triple (rows r..r+2), fetched from
//     pixel memory, with selecK_I = 1.
//   - Writes each valid convolver result to the result memory.
//
//   Ports:
//     CLK100MHZ  clock; all logic is on the rising edge
//     i_reset    asynchronous, active-high reset
//     bus        conv_feeder_if.master (frame control, pixel memory,
//                convolver column interface, result memory)
//
//   Build option:
//     CONV_FEEDER_PERF_EN  drives bus.o_cycles with the number of busy
//                          cycles of the current/last frame.
//
//   state | meaning
//   IDLE  | waiting for i_start
//   K0-K2 | push kernel column 0/1/2
//   F0    | address row r
//   F1    | address row r+1, capture row r
//   F2    | address row r+2, capture row r+1
//   F3    | capture row r+2
//   PUSH  | column strobe to the convolver
//   WR    | write result (k >= 3), advance column/row
//   DONE  | end-of-frame pulse
module conv_feeder #(
    parameter int BIT_LEN   = 8,
    parameter int CONV_LPOS = 13,
    parameter int IMG_W     = 16,
    parameter int IMG_H     = 16,
    parameter int ADDR_LEN  = 16
) (
    input  logic          CLK100MHZ,
    input  logic          i_reset,
    conv_feeder_if.master bus
);
    localparam int KW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = 3 * BIT_LEN;

    localparam logic [KW-1:0]       K_LAST = KW'(IMG_W);
    localparam logic [KW-1:0]       K_ONE  = KW'(1);
    localparam logic [KW-1:0]       K_VAL  = KW'(3);
    localparam logic [RW-1:0]       R_LAST = RW'(IMG_H - 3);
    localparam logic [RW-1:0]       R_ONE  = RW'(1);
    localparam logic [ADDR_LEN-1:0] W_A    = ADDR_LEN'(IMG_W);
    localparam logic [ADDR_LEN-1:0] W2_A   = ADDR_LEN'(2 * IMG_W);
    localparam logic [ADDR_LEN-1:0] WR_A   = ADDR_LEN'(IMG_W - 2);
    localparam logic [ADDR_LEN-1:0] THREE_A = ADDR_LEN'(3);

    typedef enum logic [3:0] {
        IDLE, K0, K1, K2, F0, F1, F2, F3, PUSH, WR, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [RW-1:0]          r_q, r_d;
    logic [ADDR_LEN-1:0]    rb_q, rb_d;          // r*IMG_W
    logic [ADDR_LEN-1:0]    res_rb_q, res_rb_d;  // r*(IMG_W-2)
    logic [2*CW-1:0]        kern_q, kern_d;      // kernel columns 1 and 2
    logic [BIT_LEN-1:0]     dato0_q, dato0_d;
    logic [BIT_LEN-1:0]     dato1_q, dato1_d;
    logic [BIT_LEN-1:0]     dato2_q, dato2_d;
    logic [ADDR_LEN-1:0]    k_a;

    assign k_a = ADDR_LEN'(k_q);

    always_ff @(posedge CLK100MHZ or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            r_q      <= '0;
            rb_q     <= '0;
            res_rb_q <= '0;
            kern_q   <= '0;
            dato0_q  <= '0;
            dato1_q  <= '0;
            dato2_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            r_q      <= r_d;
            rb_q     <= rb_d;
            res_rb_q <= res_rb_d;
            kern_q   <= kern_d;
            dato0_q  <= dato0_d;
            dato1_q  <= dato1_d;
            dato2_q  <= dato2_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        r_d      = r_q;
        rb_d     = rb_q;
        res_rb_d = res_rb_q;
        kern_d   = kern_q;
        dato0_d  = dato0_q;
        dato1_d  = dato1_q;
        dato2_d  = dato2_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    // Column 0 goes straight to the output registers so it is
                    // on the bus during K0; columns 1 and 2 wait in kern_q.
                    kern_d = bus.i_kernel[9*BIT_LEN-1:CW];
                    {dato2_d, dato1_d, dato0_d} = bus.i_kernel[CW-1:0];
                    state_d = K0;
                end
            end
            K0: begin
                {dato2_d, dato1_d, dato0_d} = kern_q[CW-1:0];
                state_d = K1;
            end
            K1: begin
                {dato2_d, dato1_d, dato0_d} = kern_q[2*CW-1:CW];
                state_d = K2;
            end
            K2: begin
                k_d      = '0;
                r_d      = '0;
                rb_d     = '0;
                res_rb_d = '0;
                state_d  = F0;
            end
            F0: state_d = F1;
            F1: begin
                dato0_d = bus.i_mem_data;
                state_d = F2;
            end
            F2: begin
                dato1_d = bus.i_mem_data;
                state_d = F3;
            end
            F3: begin
                dato2_d = bus.i_mem_data;
                state_d = PUSH;
            end
            PUSH: state_d = WR;
            WR: begin
                if (k_q != K_LAST) begin
                    k_d = k_q + K_ONE;
                    if ((k_q + K_ONE) == K_LAST) begin
                        // Zero flush column: pushes out the last window of the row.
                        dato0_d = '0;
                        dato1_d = '0;
                        dato2_d = '0;
                        state_d = PUSH;
                    end else begin
                        state_d = F0;
                    end
                end else if (r_q != R_LAST) begin
                    r_d      = r_q + R_ONE;
                    k_d      = '0;
                    rb_d     = rb_q + W_A;
                    res_rb_d = res_rb_q + WR_A;
                    state_d  = F0;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_valid    = 1'b0;
        bus.o_selecK_I = 1'b0;
        bus.o_mem_addr = '0;
        bus.o_res_we   = 1'b0;
        bus.o_res_addr = '0;
        bus.o_res_data = '0;
        bus.o_busy     = (state_q != IDLE) && (state_q != DONE);
        bus.o_done     = (state_q == DONE);
        case (state_q)
            K0, K1, K2: bus.o_valid = 1'b1;
            F0: bus.o_mem_addr = rb_q + k_a;
            F1: bus.o_mem_addr = rb_q + W_A + k_a;
            F2: bus.o_mem_addr = rb_q + W2_A + k_a;
            PUSH: begin
                bus.o_valid    = 1'b1;
                bus.o_selecK_I = 1'b1;
            end
            WR: begin
                // Pushes 0..2 of a row return a stale window.
                if (k_q >= K_VAL) begin
                    bus.o_res_we   = 1'b1;
                    bus.o_res_data = bus.i_conv_data;
                    bus.o_res_addr = res_rb_q + k_a - THREE_A;
                end
            end
            default: ;
        endcase
    end

    assign bus.o_dato0 = dato0_q;
    assign bus.o_dato1 = dato1_q;
    assign bus.o_dato2 = dato2_q;

`ifdef CONV_FEEDER_PERF_EN
    logic [31:0] cycles_q;

    always_ff @(posedge CLK100MHZ or posedge i_reset) begin
        if (i_reset) begin
            cycles_q <= '0;
        end else if (state_q == IDLE && bus.i_start) begin
            cycles_q <= '0;
        end else if (bus.o_busy) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign bus.o_cycles = cycles_q;
`endif
endmodule
